debounce_multicanal: RTL and testbench

- Parametrised, multi-channel successor to the single fixed-ratio debounce clock divider.
- Contains a programmable tick prescaler that produces the debounce sample strobe and a square-wave clk_out.
- Adds N_CH independent synchroniser + debounce FSMs with level outputs and one-cycle press/release pulses.
- Sits between raw board pushbuttons/switches and the user logic of the exercise designs.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 50 +++++
 rtl/debounce_multicanal.sv | 145 ++++++++++++++
 tb/tb_debounce_multicanal.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared debounce FSM state encoding and default timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        DEB_IDLE         = 2'd0,
        DEB_PRESS_WAIT   = 2'd1,
        DEB_PRESSED      = 2'd2,
        DEB_RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int DEFAULT_DIV          = 1000000;
    localparam int DEFAULT_STABLE_TICKS = 4;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Programmable divider giving a one-cycle sample tick every DIV
//            enabled cycles and a square wave toggling on each tick.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import debounce_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    output logic tick_out,
    output logic clk_out
);

    localparam int                CNT_W  = $clog2(DIV);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_clk;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_clk   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (enable) begin
                if (r_count == C_LAST) begin
                    r_count <= '0;
                    r_tick  <= 1'b1;
                    r_clk   <= ~r_clk;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign tick_out = r_tick;
    assign clk_out  = r_clk;

endmodule
`default_nettype wire

// File: rtl/debounce_multicanal.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multicanal
// Purpose  : N_CH synchroniser + debounce channels sampled by a shared tick,
//            with level outputs and one-cycle press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multicanal
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DIV           = DEFAULT_DIV,
    parameter int STABLE_TICKS  = DEFAULT_STABLE_TICKS,
    parameter int ACTIVE_LOW_IN = 1
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            enable,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            tick_out,
    output logic            clk_out
);

    localparam int               CNT_W      = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic             C_IDLE_LVL = (ACTIVE_LOW_IN != 0);

    logic w_tick;
    logic w_step;

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk_in  (clk_in),
        .reset   (reset),
        .enable  (enable),
        .tick_out(w_tick),
        .clk_out (clk_out)
    );

    assign tick_out = w_tick;
    // The registered tick drives the FSMs; a disabled cycle never advances them.
    assign w_step   = w_tick & enable;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             w_pressed;
        deb_state_t       r_state;
        deb_state_t       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_press;
        logic             r_release;
        logic             w_press_nxt;
        logic             w_release_nxt;

        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                r_sync1 <= C_IDLE_LVL;
                r_sync2 <= C_IDLE_LVL;
            end else begin
                r_sync1 <= btn_in[g];
                r_sync2 <= r_sync1;
            end
        end

        assign w_pressed = r_sync2 ^ C_IDLE_LVL;

        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                r_state   <= DEB_IDLE;
                r_cnt     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            if (w_step) begin
                case (r_state)
                    DEB_IDLE: begin
                        if (w_pressed) begin
                            w_state_nxt = DEB_PRESS_WAIT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                    DEB_PRESS_WAIT: begin
                        if (!w_pressed) begin
                            w_state_nxt = DEB_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            w_state_nxt = DEB_PRESSED;
                            w_cnt_nxt   = '0;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt   = r_cnt + 1'b1;
                        end
                    end
                    DEB_PRESSED: begin
                        if (!w_pressed) begin
                            w_state_nxt = DEB_RELEASE_WAIT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                    DEB_RELEASE_WAIT: begin
                        if (w_pressed) begin
                            w_state_nxt   = DEB_PRESSED;
                            w_cnt_nxt     = '0;
                        end else if (r_cnt == C_CNT_LAST) begin
                            w_state_nxt   = DEB_IDLE;
                            w_cnt_nxt     = '0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt     = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = DEB_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end

        // Debounced level is a state decode, so it flips on the same edge as the strobes.
        assign btn_out[g]       = (r_state == DEB_PRESSED) || (r_state == DEB_RELEASE_WAIT);
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multicanal.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multicanal
// Purpose  : Directed bench; active-low and active-high instances share one
//            expected timeline. Packed check word: {btn,press,release,tick,clk}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multicanal;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] btn    = 2'b11;
    logic [1:0] btn_inv;

    logic [1:0] btn_out_l, press_l, release_l;
    logic       tick_l, clk_out_l;
    logic [1:0] btn_out_h, press_h, release_h;
    logic       tick_h, clk_out_h;

    int vectors     = 0;
    int miscompares = 0;
    int cur         = 0;

    assign btn_inv = ~btn;

    always #5 clk_in = ~clk_in;

    debounce_multicanal #(
        .N_CH(2), .DIV(4), .STABLE_TICKS(3), .ACTIVE_LOW_IN(1)
    ) dut_low (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .btn_in       (btn),
        .btn_out      (btn_out_l),
        .press_pulse  (press_l),
        .release_pulse(release_l),
        .tick_out     (tick_l),
        .clk_out      (clk_out_l)
    );

    debounce_multicanal #(
        .N_CH(2), .DIV(4), .STABLE_TICKS(3), .ACTIVE_LOW_IN(0)
    ) dut_high (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .btn_in       (btn_inv),
        .btn_out      (btn_out_h),
        .press_pulse  (press_h),
        .release_pulse(release_h),
        .tick_out     (tick_h),
        .clk_out      (clk_out_h)
    );

    // Advance to absolute rising edge n, then settle 1 time unit.
    task automatic go(input int n);
        repeat (n - cur) @(posedge clk_in);
        #1;
        cur = n;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs_l, obs_h;
        obs_l = {btn_out_l, press_l, release_l, tick_l, clk_out_l};
        obs_h = {btn_out_h, press_h, release_h, tick_h, clk_out_h};
        vectors++;
        assert (obs_l === exp) else begin
            miscompares++;
            $error("FAIL %s/low: observed %b expected %b", tag, obs_l, exp);
        end
        vectors++;
        assert (obs_h === exp) else begin
            miscompares++;
            $error("FAIL %s/high: observed %b expected %b", tag, obs_h, exp);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        go(1);   chk("reset",        8'b00_00_00_0_0);
        go(2);   reset = 1'b1;
        go(5);   chk("pre_tick",     8'b00_00_00_0_0);
        go(6);   chk("tick1",        8'b00_00_00_1_1);
        go(7);   chk("tick1_end",    8'b00_00_00_0_1);
        go(10);  chk("tick2",        8'b00_00_00_1_0);

        go(12);  btn = 2'b10;
        go(14);  chk("press_wait",   8'b00_00_00_1_1);
        go(22);  chk("pre_accept",   8'b00_00_00_1_1);
        go(23);  chk("press_acc",    8'b01_01_00_0_1);
        go(24);  chk("press_end",    8'b01_00_00_0_1);

        btn = 2'b11;
        go(28);  btn = 2'b10;
        go(32);  btn = 2'b11;
        go(35);  chk("bounce_hold",  8'b01_00_00_0_0);
        go(42);  chk("rel_pre",      8'b01_00_00_1_0);
        go(43);  chk("release_acc",  8'b00_00_01_0_0);
        go(44);  chk("release_end",  8'b00_00_00_0_0);

        btn = 2'b10;
        go(50);  btn = 2'b11;
        go(51);  chk("glitch_mid",   8'b00_00_00_0_0);
        go(55);  chk("glitch_done",  8'b00_00_00_0_1);
        go(56);  btn = 2'b10;
        go(63);  chk("repeat_wait",  8'b00_00_00_0_1);
        go(66);  chk("repeat_pre",   8'b00_00_00_1_0);
        go(67);  chk("repeat_acc",   8'b01_01_00_0_0);
        go(68);  chk("repeat_end",   8'b01_00_00_0_0);

        btn = 2'b00;
        go(70);  chk("ch1_tick",     8'b01_00_00_1_1);
        go(71);  chk("ch1_wait1",    8'b01_00_00_0_1);
        go(72);  enable = 1'b0;
        go(74);  chk("frozen_a",     8'b01_00_00_0_1);
        go(90);  chk("frozen_b",     8'b01_00_00_0_1);
        go(92);  enable = 1'b1;
        go(93);  chk("resume",       8'b01_00_00_0_1);
        go(94);  chk("resume_tick",  8'b01_00_00_1_0);
        go(98);  chk("ch1_pre",      8'b01_00_00_1_1);
        go(99);  chk("ch1_acc",      8'b11_10_00_0_1);
        go(100); chk("ch1_end",      8'b11_00_00_0_1);

        #2 reset = 1'b0;
        #1 chk("async_reset",        8'b00_00_00_0_0);
        go(101); chk("in_reset",     8'b00_00_00_0_0);
        go(102); reset = 1'b1;
        go(106); chk("post_tick1",   8'b00_00_00_1_1);
        go(114); chk("post_pre",     8'b00_00_00_1_1);
        go(115); chk("both_acc",     8'b11_11_00_0_1);
        go(116); chk("both_end",     8'b11_00_00_0_1);
        go(120); chk("no_repeat",    8'b11_00_00_0_0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
